// File: rtl/corridor_episode_scorer.sv
// Turns the corridor environment's per-step error/objective flags into scored episodes
// with a terminal verdict, plus run-wide episode and goal counters.
module corridor_episode_scorer #(
  parameter int MAX_STEPS = 16,
  parameter int STEP_W    = 8,
  parameter int REWARD_W  = 12,
  parameter int STEP_COST = 1,
  parameter int BONUS     = 100,
  parameter int PENALTY   = 50,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_valid,
  input  logic                       error,
  input  logic                       objective,
  input  logic                       episode_restart,
  output logic                       done,
  output logic                       done_pulse,
  output logic [1:0]                 verdict,
  output logic [STEP_W-1:0]          step_count,
  output logic signed [REWARD_W-1:0] reward,
  output logic [CNT_W-1:0]           episode_count,
  output logic [CNT_W-1:0]           goal_count
);

  typedef enum logic [1:0] {IDLE, RUN, TERM} state_t;

  localparam logic [1:0] V_RUNNING = 2'd0;
  localparam logic [1:0] V_FAIL    = 2'd1;
  localparam logic [1:0] V_GOAL    = 2'd2;
  localparam logic [1:0] V_TIMEOUT = 2'd3;

  // Two guard bits so the combined cost/penalty/bonus update cannot wrap before clamping.
  localparam int RW2 = REWARD_W + 2;
  localparam logic signed [RW2-1:0] R_MAX = RW2'((2 ** (REWARD_W - 1)) - 1);
  localparam logic signed [RW2-1:0] R_MIN = RW2'(-(2 ** (REWARD_W - 1)));

  state_t                     state;
  logic [STEP_W-1:0]          n_next;
  logic signed [RW2-1:0]      r_wide;
  logic signed [REWARD_W-1:0] r_sat;
  logic [1:0]                 v_next;

  always_comb begin
    n_next = step_count + STEP_W'(1);
    r_wide = RW2'(reward) - RW2'(STEP_COST);
    v_next = V_RUNNING;
    if (error) begin
      v_next = V_FAIL;
      r_wide = r_wide - RW2'(PENALTY);
    end else if (objective) begin
      v_next = V_GOAL;
      r_wide = r_wide + RW2'(BONUS);
    end else if (n_next == STEP_W'(MAX_STEPS)) begin
      v_next = V_TIMEOUT;
    end
    if (r_wide > R_MAX) begin
      r_sat = R_MAX[REWARD_W-1:0];
    end else if (r_wide < R_MIN) begin
      r_sat = R_MIN[REWARD_W-1:0];
    end else begin
      r_sat = r_wide[REWARD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      done          <= 1'b0;
      done_pulse    <= 1'b0;
      verdict       <= V_RUNNING;
      step_count    <= '0;
      reward        <= '0;
      episode_count <= '0;
      goal_count    <= '0;
    end else begin
      done_pulse <= 1'b0;
      // Restart outranks any step arriving on the same edge; that step is dropped.
      if (episode_restart) begin
        state      <= RUN;
        done       <= 1'b0;
        verdict    <= V_RUNNING;
        step_count <= '0;
        reward     <= '0;
        if (episode_count != '1) begin
          episode_count <= episode_count + CNT_W'(1);
        end
      end else if (state == RUN && step_valid) begin
        step_count <= n_next;
        reward     <= r_sat;
        verdict    <= v_next;
        if (v_next != V_RUNNING) begin
          state      <= TERM;
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end
        if (v_next == V_GOAL && goal_count != '1) begin
          goal_count <= goal_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_corridor_episode_scorer.sv
// Bench for corridor_episode_scorer: directed episodes plus random traffic, each cycle's
// expected outputs come from an integer episode model and are checked by a separate monitor.
module tb_corridor_episode_scorer;

  localparam int MAX_STEPS = 16;
  localparam int REWARD_W  = 12;
  localparam int CNT_W     = 16;
  localparam int STEP_COST = 1;
  localparam int BONUS     = 100;
  localparam int PENALTY   = 50;
  localparam int RMAX      = 2047;
  localparam int RMIN      = -2048;
  localparam int CMAX      = 65535;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       step_valid = 1'b0;
  logic                       error = 1'b0;
  logic                       objective = 1'b0;
  logic                       episode_restart = 1'b0;
  logic                       done;
  logic                       done_pulse;
  logic [1:0]                 verdict;
  logic [7:0]                 step_count;
  logic signed [REWARD_W-1:0] reward;
  logic [CNT_W-1:0]           episode_count;
  logic [CNT_W-1:0]           goal_count;

  corridor_episode_scorer #(
    .MAX_STEPS(MAX_STEPS), .STEP_W(8), .REWARD_W(REWARD_W), .STEP_COST(STEP_COST),
    .BONUS(BONUS), .PENALTY(PENALTY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_valid(step_valid), .error(error),
    .objective(objective), .episode_restart(episode_restart), .done(done),
    .done_pulse(done_pulse), .verdict(verdict), .step_count(step_count),
    .reward(reward), .episode_count(episode_count), .goal_count(goal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int done_e, pulse, verd, steps, rew, ep, goal;
  } snap_t;

  snap_t q[$];
  int checks = 0;
  int errors = 0;

  // Episode model: running flag, terminal flag, plain integer score bookkeeping.
  bit m_running, m_over;
  int m_steps, m_rew, m_verd, m_ep, m_goal, m_pulse;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_running = 0; m_over = 0;
    m_steps = 0; m_rew = 0; m_verd = 0; m_ep = 0; m_goal = 0; m_pulse = 0;
  endfunction

  function automatic void model_edge(bit v, bit e, bit o, bit r);
    m_pulse = 0;
    if (r) begin
      m_running = 1; m_over = 0;
      m_steps = 0; m_rew = 0; m_verd = 0;
      if (m_ep < CMAX) m_ep++;
    end else if (m_running && v) begin
      int gain;
      m_steps++;
      gain = -STEP_COST;
      if (e) gain -= PENALTY;
      else if (o) gain += BONUS;
      m_rew += gain;
      if (m_rew > RMAX) m_rew = RMAX;
      if (m_rew < RMIN) m_rew = RMIN;
      if (e) m_verd = 1;
      else if (o) m_verd = 2;
      else if (m_steps == MAX_STEPS) m_verd = 3;
      if (m_verd != 0) begin
        m_running = 0; m_over = 1; m_pulse = 1;
        if (m_verd == 2 && m_goal < CMAX) m_goal++;
      end
    end
  endfunction

  task automatic cyc(input bit v, input bit e, input bit o, input bit r);
    snap_t s;
    step_valid = v; error = e; objective = o; episode_restart = r;
    @(posedge clk);
    model_edge(v, e, o, r);
    #1;
    s.done_e = m_over; s.pulse = m_pulse; s.verd = m_verd; s.steps = m_steps;
    s.rew = m_rew; s.ep = m_ep; s.goal = m_goal;
    q.push_back(s);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pulse"}, int'(done_pulse), 0);
    chk({tag, "_verdict"}, int'(verdict), 0);
    chk({tag, "_steps"}, int'(step_count), 0);
    chk({tag, "_reward"}, int'(reward), 0);
    chk({tag, "_episodes"}, int'(episode_count), 0);
    chk({tag, "_goals"}, int'(goal_count), 0);
  endtask

  // Monitor: every cycle the DUT presents registered outputs, compare with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        snap_t s;
        s = q.pop_front();
        chk("done", int'(done), s.done_e);
        chk("done_pulse", int'(done_pulse), s.pulse);
        chk("verdict", int'(verdict), s.verd);
        chk("step_count", int'(step_count), s.steps);
        chk("reward", int'(reward), s.rew);
        chk("episode_count", int'(episode_count), s.ep);
        chk("goal_count", int'(goal_count), s.goal);
        $display("cycle t=%0t verdict=%0d steps=%0d reward=%0d ep=%0d goals=%0d pulse=%0d",
                 $time, verdict, step_count, reward, episode_count, goal_count, done_pulse);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #23;
    check_zero("in_reset");
    #1 rst_n = 1'b1;

    // Steps before any restart must be ignored.
    repeat (5) cyc(1, 1, 0, 0);

    // Goal on step 4: reward 96.
    cyc(0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // Error and objective together: FAIL wins, reward -52.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);

    // Timeout after 16 quiet steps, then further steps ignored.
    cyc(0, 0, 0, 1);
    repeat (16) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 1, 0);

    // Goal on the final step is a goal, not a timeout.
    cyc(0, 0, 0, 1);
    repeat (15) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Restart with a simultaneous failing step mid-episode.
    cyc(0, 0, 0, 1);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    repeat (2) cyc(1, 0, 0, 0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) cyc(1, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, v, e, o;
      r = ($urandom_range(0, 99) < 5);
      v = ($urandom_range(0, 99) < 65);
      e = ($urandom_range(0, 99) < 5);
      o = ($urandom_range(0, 99) < 6);
      cyc(v, e, o, r);
    end

    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corridor_episode_scorer.md
Name: corridor_episode_scorer

Overview:
- Downstream stage of the corridor environment model. Consumes the model's per-step `error`/`objective` outputs and turns a stream of steps into scored episodes.
- Per episode: tracks step count and accumulated reward, and decides the terminal verdict (fail, goal or timeout).
- Keeps run-wide episode and goal counters for the RL tester harness.

Parameters:
- MAX_STEPS, 16, steps after which a running episode times out (1..2^STEP_W-1).
- STEP_W, 8, width of step_count.
- REWARD_W, 12, width of signed reward accumulator.
- STEP_COST, 1, reward subtracted on every accepted step.
- BONUS, 100, reward added when the episode reaches the goal.
- PENALTY, 50, reward subtracted when the episode fails.
- CNT_W, 16, width of episode_count and goal_count.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- step_valid  in  1  error/objective reflect a newly completed environment step this cycle.
- error  in  1  environment error flag (sticky in the source model).
- objective  in  1  environment objective flag.
- episode_restart  in  1  start a new episode (synchronous).
- done  out  1  episode in terminal state.
- done_pulse  out  1  one-cycle pulse on entry to terminal state.
- verdict  out  2  0 RUNNING, 1 FAIL, 2 GOAL, 3 TIMEOUT.
- step_count  out  STEP_W  accepted steps in current episode.
- reward  out  REWARD_W signed  accumulated episode reward.
- episode_count  out  CNT_W  episodes started since reset.
- goal_count  out  CNT_W  episodes ended in GOAL since reset.

Behaviour:
- Reset, asynchronous on rst_n low and effective without a clock edge:
  - state=IDLE;
  - all outputs 0 (verdict RUNNING, done=0, done_pulse=0, step_count=0, reward=0, both counters 0).
- States: IDLE, RUN, TERM. done=1 only in TERM.
- episode_restart in any state, on the next edge:
  - state=RUN;
  - step_count=0, reward=0, verdict=RUNNING, done_pulse=0;
  - episode_count+1, saturating at all-ones.
- Restart priority: episode_restart wins over a simultaneous step_valid. That step is discarded, with no count, reward or verdict effect.
- Restart during RUN aborts the current episode silently. No verdict and no goal_count change.
- step_valid in IDLE or TERM is ignored.
- In RUN with step_valid=1, all in one edge (verdict visible the cycle after the step edge):
  - n = step_count+1;
  - r = reward-STEP_COST;
  - if error: verdict=FAIL, r -= PENALTY, go to TERM;
  - else if objective: verdict=GOAL, r += BONUS, goal_count+1 (saturating), go to TERM;
  - else if n == MAX_STEPS: verdict=TIMEOUT, go to TERM;
  - else stay in RUN;
  - step_count=n, reward=r.
- Verdict priority: error beats objective beats timeout. A goal on the final step (n==MAX_STEPS) is GOAL, not TIMEOUT.
- Arithmetic:
  - reward is computed at REWARD_W+2 bits and saturates to [-2^(REWARD_W-1), 2^(REWARD_W-1)-1] after each step's combined update;
  - step_count cannot exceed MAX_STEPS.
- done_pulse is high for exactly the one cycle following the edge that entered TERM. It is 0 otherwise, including while remaining in TERM.
- In TERM, step_count, reward and verdict hold until restart or reset.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset released, no restart, step_valid=1 with error=1 for 5 cycles -> state stays IDLE, all outputs 0, episode_count=0.
- Restart; 3 quiet steps; 4th step objective=1 -> verdict=2, step_count=4, reward=96, goal_count=1, episode_count=1, done_pulse high exactly 1 cycle.
- Restart; step 1 quiet; step 2 error=1 and objective=1 -> verdict=1, step_count=2, reward=-52, goal_count unchanged at 1.
- Restart; 16 quiet steps -> verdict=3 after 16th step, step_count=16, reward=-16; further step_valid ignored (step_count stays 16).
- Mid-RUN at step 5: restart together with step_valid and error=1 -> RUN, step_count=0, reward=0, verdict=0, episode_count incremented, no FAIL.
- Mid-RUN, rst_n pulsed low between clock edges -> all outputs 0 immediately before the next edge; after release, state stays IDLE until restart.
